// File: rtl/ram_controller_if.sv
// Requester-side handshake for ram_controller: one byte read or write per req/ack exchange.
interface ram_controller_if;
  logic        req;
  logic        wr;
  logic [17:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ack;
  logic        parity_err;
  logic        busy;

  modport master (
    output req, wr, addr, wdata,
    input  rdata, ack, parity_err, busy
  );

  modport slave (
    input  req, wr, addr, wdata,
    output rdata, ack, parity_err, busy
  );
endinterface

// File: rtl/ram_controller.sv
// Sequences row/column strobes for four parity-protected ram_bank instances,
// interleaving periodic refresh cycles that take priority over requester traffic.
module ram_controller #(
  parameter int REFRESH_INTERVAL = 72
) (
  input  logic            clk,
  input  logic            rst,
  ram_controller_if.slave bus,
  output logic [7:0]      ma,
  output logic [3:0]      ras_n,
  output logic [3:0]      cas_n,
  output logic [3:0]      we_n,
  inout  wire  [7:0]      md,
  inout  wire             mdp
);

  localparam int CNT_W = $clog2(REFRESH_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);

  typedef enum logic [2:0] {IDLE, ROW, COL, WR, RD1, RD2, PRE} state_t;

  state_t           state;
  state_t           state_nxt;

  logic [1:0]       cur_bank;
  logic [7:0]       cur_row;
  logic [7:0]       cur_col;
  logic [7:0]       cur_wdata;
  logic             cur_wr;
  logic             cur_ref;

  logic [7:0]       rdata_q;
  logic             err_flag;

  logic [CNT_W-1:0] ref_cnt;
  logic             ref_pending;
  logic [9:0]       ref_addr;

  logic [3:0]       bank_sel;
  logic             md_oe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Every state lasts one clock; a refresh is a dummy read that skips RD2.
  always_comb begin
    state_nxt = state;
    ma        = 8'h00;
    ras_n     = 4'hF;
    cas_n     = 4'hF;
    we_n      = 4'hF;
    md_oe     = 1'b0;
    bank_sel  = 4'b0001 << cur_bank;
    unique case (state)
      IDLE: begin
        if (ref_pending || bus.req) begin
          state_nxt = ROW;
        end
      end
      ROW: begin
        ras_n     = ~bank_sel;
        ma        = cur_row;
        state_nxt = COL;
      end
      COL: begin
        ras_n     = ~bank_sel;
        cas_n     = ~bank_sel;
        ma        = cur_col;
        state_nxt = cur_wr ? WR : RD1;
      end
      WR: begin
        ras_n     = ~bank_sel;
        cas_n     = ~bank_sel;
        we_n      = ~bank_sel;
        ma        = cur_col;
        md_oe     = 1'b1;
        state_nxt = PRE;
      end
      RD1: begin
        ras_n     = ~bank_sel;
        cas_n     = ~bank_sel;
        ma        = cur_col;
        state_nxt = cur_ref ? PRE : RD2;
      end
      RD2: begin
        ras_n     = ~bank_sel;
        cas_n     = ~bank_sel;
        ma        = cur_col;
        state_nxt = PRE;
      end
      PRE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A pending refresh wins the IDLE slot; a waiting request is latched on a later IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_bank  <= 2'd0;
      cur_row   <= 8'h00;
      cur_col   <= 8'h00;
      cur_wdata <= 8'h00;
      cur_wr    <= 1'b0;
      cur_ref   <= 1'b0;
    end else if (state == IDLE) begin
      if (ref_pending) begin
        cur_bank <= ref_addr[9:8];
        cur_row  <= ref_addr[7:0];
        cur_col  <= 8'h00;
        cur_wr   <= 1'b0;
        cur_ref  <= 1'b1;
      end else if (bus.req) begin
        cur_bank  <= bus.addr[17:16];
        cur_row   <= bus.addr[15:8];
        cur_col   <= bus.addr[7:0];
        cur_wdata <= bus.wdata;
        cur_wr    <= bus.wr;
        cur_ref   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= 8'h00;
      err_flag <= 1'b0;
    end else if (state == RD2 && !cur_ref) begin
      rdata_q  <= md;
      err_flag <= ~^{md, mdp};
    end
  end

  // Free-running interval counter; an expiry while still pending simply leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      ref_addr    <= 10'h000;
    end else begin
      if (ref_cnt == CNT_LAST) begin
        ref_cnt     <= '0;
        ref_pending <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt + CNT_W'(1);
        if (state == IDLE && ref_pending) begin
          ref_pending <= 1'b0;
        end
      end
      if (state == PRE && cur_ref) begin
        ref_addr <= ref_addr + 10'd1;
      end
    end
  end

  assign md  = md_oe ? cur_wdata : 8'hzz;
  assign mdp = md_oe ? ~^cur_wdata : 1'bz;

  assign bus.rdata      = rdata_q;
  assign bus.ack        = (state == PRE) && !cur_ref;
  assign bus.parity_err = (state == PRE) && !cur_ref && !cur_wr && err_flag;
  assign bus.busy       = (state != IDLE);

endmodule
